// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Multi-cycle command issuer for the 2-bit-command datapath ALU
// (ADD / ROR1 / NAND / PASS). Compound operations (AND, XOR, SUB, MUL, RORN,
// CMP) are built from ALU primitives, one primitive per clock. Requests come
// in from decode over valid/ready and results leave to writeback over
// valid/ready.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_op                000 AND, 001 XOR, 010 SUB, 011 MUL, 100 RORN,
//                         101 CMP, 11x illegal
//   req_a, req_b          operands (RORN: req_b[2:0] is the rotate amount)
//   rsp_valid/rsp_ready   response handshake; rsp_* held until accepted
//   rsp_data              result
//   rsp_zero, rsp_pari    result == 0 and XOR-reduction of result
//   rsp_eq                CMP only: a == b
//   rsp_err               illegal opcode
//   alu_cmd               10 ADD, 01 ROR1, 00 NAND, 11 PASS
//   alu_a, alu_b, alu_sc  ALU operands; carry-in tied low
//   alu_rslt, alu_neq     ALU result (same cycle) and inA != inB
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DW = 8  // must match the ALU width; only 8 is supported
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero,
    output logic          rsp_pari,
    output logic          rsp_eq,
    output logic          rsp_err,
    output logic [1:0]    alu_cmd,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_sc,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_neq
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // Which register captures alu_rslt on the current RUN step.
    typedef enum logic [2:0] {DST_NONE, DST_T, DST_U, DST_R, DST_MA} dst_e;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_RORN = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;

    localparam logic [1:0] CMD_NAND = 2'b00;
    localparam logic [1:0] CMD_ROR1 = 2'b01;
    localparam logic [1:0] CMD_ADD  = 2'b10;
    localparam logic [1:0] CMD_PASS = 2'b11;

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d;      // operand A; MUL multiplicand (doubles each iteration)
    logic [DW-1:0] b_q, b_d;      // operand B; MUL multiplier (shifts right each iteration)
    logic [DW-1:0] t_q, t_d;
    logic [DW-1:0] u_q, u_d;
    logic [DW-1:0] r_q, r_d;      // result / MUL accumulator / XOR nand(a,b) scratch
    logic [3:0]    step_q, step_d;
    logic          eq_q, eq_d;
    logic          err_q, err_d;

    dst_e          dst;
    logic [3:0]    last_step;

    // Issue side: ALU command and operands depend only on registered state, so
    // the combinational path through the external ALU never loops back here.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_cmd   = CMD_PASS;
        alu_a     = '0;
        alu_b     = '0;
        dst       = DST_NONE;
        last_step = 4'd0;
        if (state_q == S_RUN) begin
            unique case (op_q)
                OP_AND: begin
                    last_step = 4'd1;
                    alu_cmd   = CMD_NAND;
                    if (step_q == 4'd0) begin
                        alu_a = a_q;  alu_b = b_q;  dst = DST_T;
                    end else begin
                        alu_a = t_q;  alu_b = t_q;  dst = DST_R;
                    end
                end
                OP_XOR: begin
                    last_step = 4'd3;
                    alu_cmd   = CMD_NAND;
                    unique case (step_q[1:0])
                        2'd0:    begin alu_a = a_q; alu_b = b_q; dst = DST_R; end
                        2'd1:    begin alu_a = a_q; alu_b = r_q; dst = DST_T; end
                        2'd2:    begin alu_a = b_q; alu_b = r_q; dst = DST_U; end
                        default: begin alu_a = t_q; alu_b = u_q; dst = DST_R; end
                    endcase
                end
                OP_SUB: begin
                    // a - b = a + (~b + 1)
                    last_step = 4'd2;
                    unique case (step_q[1:0])
                        2'd0:    begin alu_cmd = CMD_NAND; alu_a = b_q; alu_b = b_q;  dst = DST_T; end
                        2'd1:    begin alu_cmd = CMD_ADD;  alu_a = t_q; alu_b = DW'(1); dst = DST_T; end
                        default: begin alu_cmd = CMD_ADD;  alu_a = a_q; alu_b = t_q;  dst = DST_R; end
                    endcase
                end
                OP_MUL: begin
                    // Even step: conditional accumulate. Odd step: double the
                    // multiplicand. Always 16 steps regardless of data.
                    last_step = 4'd15;
                    if (!step_q[0]) begin
                        alu_a = r_q;
                        dst   = DST_R;
                        if (b_q[0]) begin
                            alu_cmd = CMD_ADD;
                            alu_b   = a_q;
                        end
                    end else begin
                        alu_cmd = CMD_ADD;
                        alu_a   = a_q;
                        alu_b   = a_q;
                        dst     = DST_MA;
                    end
                end
                OP_RORN: begin
                    // r was preloaded with a at acceptance; amount 0 is one PASS.
                    alu_a = r_q;
                    dst   = DST_R;
                    if (b_q[2:0] != 3'd0) begin
                        alu_cmd   = CMD_ROR1;
                        last_step = {1'b0, b_q[2:0]} - 4'd1;
                    end
                end
                OP_CMP: begin
                    alu_a = a_q;
                    alu_b = b_q;
                    dst   = DST_R;
                end
                default: begin
                    alu_a = a_q;
                    dst   = DST_R;
                end
            endcase
        end
    end

    // Next-state side: captures the ALU result and sequences the FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        t_d     = t_q;
        u_d     = u_q;
        r_d     = r_q;
        step_d  = step_q;
        eq_d    = eq_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    r_d     = (req_op == OP_RORN) ? req_a : '0;
                    step_d  = 4'd0;
                    eq_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                unique case (dst)
                    DST_T:   t_d = alu_rslt;
                    DST_U:   u_d = alu_rslt;
                    DST_R:   r_d = alu_rslt;
                    DST_MA:  begin a_d = alu_rslt; b_d = b_q >> 1; end
                    default: ;
                endcase
                if (op_q == OP_CMP)      eq_d  = ~alu_neq;
                if (op_q[2:1] == 2'b11)  err_d = 1'b1;
                if (step_q == last_step) state_d = S_DONE;
                else                     step_d  = step_q + 4'd1;
            end
            S_DONE: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            t_q     <= '0;
            u_q     <= '0;
            r_q     <= '0;
            step_q  <= '0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            t_q     <= t_d;
            u_q     <= u_d;
            r_q     <= r_d;
            step_q  <= step_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
        end
    end

    // req_ready is qualified by reset_n so every handshake output reads 0
    // while reset is held, even though the FSM already sits in IDLE.
    assign req_ready = (state_q == S_IDLE) && reset_n;
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_data  = r_q;
    assign rsp_zero  = rsp_valid && (r_q == '0);
    assign rsp_pari  = rsp_valid && (^r_q);
    assign rsp_eq    = eq_q;
    assign rsp_err   = err_q;
    assign alu_sc    = 1'b0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Bench for alu_op_sequencer. Provides a behavioural model of the external
// ALU, drives directed and random requests, and compares each response with
// a reference computed directly from the arithmetic meaning of each opcode.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'd0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;
    logic          rsp_pari;
    logic          rsp_eq;
    logic          rsp_err;
    logic [1:0]    alu_cmd;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_sc;
    logic [DW-1:0] alu_rslt;
    logic          alu_neq;

    int total = 0;
    int bad   = 0;

    logic [1:0] last_cmds[$];

    typedef struct packed {
        logic [7:0] data;
        logic       eq;
        logic       err;
        int         lat;
    } exp_t;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_pari  (rsp_pari),
        .rsp_eq    (rsp_eq),
        .rsp_err   (rsp_err),
        .alu_cmd   (alu_cmd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sc    (alu_sc),
        .alu_rslt  (alu_rslt),
        .alu_neq   (alu_neq)
    );

    // External datapath ALU
    always_comb begin
        alu_rslt = alu_a;
        case (alu_cmd)
            2'b10:   alu_rslt = alu_a + alu_b;
            2'b01:   alu_rslt = {alu_a[0], alu_a[DW-1:1]};
            2'b00:   alu_rslt = ~(alu_a & alu_b);
            default: alu_rslt = alu_a;
        endcase
        alu_neq = (alu_a != alu_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        m;
        logic [15:0] prod;
        logic [15:0] dbl;
        int          amt;
        m.eq  = 1'b0;
        m.err = 1'b0;
        case (op)
            3'd0: begin m.data = a & b; m.lat = 2; end
            3'd1: begin m.data = a ^ b; m.lat = 4; end
            3'd2: begin m.data = a - b; m.lat = 3; end
            3'd3: begin prod = a * b; m.data = prod[7:0]; m.lat = 16; end
            3'd4: begin
                amt    = int'(b[2:0]);
                dbl    = {a, a} >> amt;
                m.data = dbl[7:0];
                m.lat  = (amt == 0) ? 1 : amt;
            end
            3'd5: begin m.data = a; m.eq = (a == b); m.lat = 1; end
            default: begin m.data = a; m.err = 1'b1; m.lat = 1; end
        endcase
        return m;
    endfunction

    // Issue one request, wait for its response, optionally stall the
    // response for `hold` cycles, then complete the handshake.
    task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int hold);
        exp_t e;
        int   cyc;
        e = model(op, a, b);
        last_cmds.delete();
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        check($sformatf("%s req_ready", name), 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        cyc = 0;
        do begin
            last_cmds.push_back(alu_cmd);
            @(posedge clk);
            #1;
            cyc++;
        end while (!rsp_valid && cyc < 40);
        check($sformatf("%s latency", name), 32'(cyc), 32'(e.lat));
        check($sformatf("%s data", name), 32'(rsp_data), 32'(e.data));
        check($sformatf("%s zero", name), 32'(rsp_zero), 32'(e.data == 8'h00));
        check($sformatf("%s pari", name), 32'(rsp_pari), 32'(^e.data));
        check($sformatf("%s eq", name), 32'(rsp_eq), 32'(e.eq));
        check($sformatf("%s err", name), 32'(rsp_err), 32'(e.err));
        check($sformatf("%s sc", name), 32'(alu_sc), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s hold valid", name), 32'(rsp_valid), 32'd1);
            check($sformatf("%s hold data", name), 32'(rsp_data), 32'(e.data));
            check($sformatf("%s hold req_ready", name), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check($sformatf("%s valid dropped", name), 32'(rsp_valid), 32'd0);
        check($sformatf("%s ready after rsp", name), 32'(req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check($sformatf("%s rsp_valid", name), 32'(rsp_valid), 32'd0);
        check($sformatf("%s req_ready", name), 32'(req_ready), 32'd0);
        check($sformatf("%s rsp_data", name), 32'(rsp_data), 32'd0);
        check($sformatf("%s rsp_zero", name), 32'(rsp_zero), 32'd0);
        check($sformatf("%s rsp_pari", name), 32'(rsp_pari), 32'd0);
        check($sformatf("%s rsp_eq", name), 32'(rsp_eq), 32'd0);
        check($sformatf("%s rsp_err", name), 32'(rsp_err), 32'd0);
        check($sformatf("%s alu_cmd", name), 32'(alu_cmd), 32'd3);
        check($sformatf("%s alu_a", name), 32'(alu_a), 32'd0);
        check($sformatf("%s alu_b", name), 32'(alu_b), 32'd0);
        check($sformatf("%s alu_sc", name), 32'(alu_sc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;

        // Reset state
        #12;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle req_ready", 32'(req_ready), 32'd1);
        check("idle alu_cmd", 32'(alu_cmd), 32'd3);

        // SUB with command trace
        run_op("sub 05-07", 3'b010, 8'h05, 8'h07, 0);
        check("sub cmd count", 32'(last_cmds.size()), 32'd3);
        if (last_cmds.size() == 3) begin
            check("sub cmd0", 32'(last_cmds[0]), 32'd0);
            check("sub cmd1", 32'(last_cmds[1]), 32'd2);
            check("sub cmd2", 32'(last_cmds[2]), 32'd2);
        end

        // MUL, XOR, AND, RORN, CMP directed cases
        run_op("mul 0d*14", 3'b011, 8'h0D, 8'h14, 0);
        run_op("mul ff*ff", 3'b011, 8'hFF, 8'hFF, 0);
        run_op("xor a5^a5", 3'b001, 8'hA5, 8'hA5, 0);
        run_op("and f0&3c", 3'b000, 8'hF0, 8'h3C, 0);
        run_op("rorn 81>>3", 3'b100, 8'h81, 8'h03, 0);
        run_op("rorn 81>>0", 3'b100, 8'h81, 8'h00, 0);
        run_op("rorn 81>>7", 3'b100, 8'h81, 8'h07, 0);
        run_op("cmp 42,42", 3'b101, 8'h42, 8'h42, 0);
        run_op("cmp 42,43", 3'b101, 8'h42, 8'h43, 0);

        // Response back-pressure
        run_op("and hold5", 3'b000, 8'h5A, 8'hC3, 5);
        run_op("xor back2back", 3'b001, 8'h12, 8'h34, 0);

        // Reset in the middle of a MUL
        req_op    = 3'b011;
        req_a     = 8'h0D;
        req_b     = 8'h14;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid-mul reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset held valid", 32'(rsp_valid), 32'd0);
        reset_n = 1'b1;
        #1;
        run_op("sub 09-04", 3'b010, 8'h09, 8'h04, 0);

        // Illegal opcodes
        run_op("illegal 110", 3'b110, 8'h7E, 8'h11, 0);
        run_op("illegal 111", 3'b111, 8'h00, 8'hFF, 1);

        // Random requests
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            run_op($sformatf("rand%0d op%0d a%0h b%0h", i, rop, ra, rb), rop, ra, rb,
                   int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
